// File: rtl/adma_desc_queue.sv
// Per-channel DMA descriptor queue: buffers descriptors, issues them one at a
// time to the transfer engine and tracks per-slot completion and IRQ sources.
`timescale 1ns/1ps
module adma_desc_queue #(
    parameter int DMA_DESC_DEPTH = 4,
    parameter int DMA_LENGTH_W   = 16,
    parameter int SRC_ADDR_W     = 32,
    parameter int DST_ADDR_W     = 32,
    parameter int DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      dma_en_i,
    input  logic                      chn_en_i,
    input  logic                      chn_cyclic_i,
    input  logic                      irq_msk_com_i,
    input  logic                      irq_msk_qed_i,
    input  logic                      desc_wr_vld_i,
    output logic                      desc_wr_rdy_o,
    input  logic [SRC_ADDR_W-1:0]     desc_src_addr_i,
    input  logic [DST_ADDR_W-1:0]     desc_dst_addr_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_xlen_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_ylen_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_src_strd_i,
    input  logic [DMA_LENGTH_W-1:0]   desc_dst_strd_i,
    output logic                      issue_vld_o,
    input  logic                      issue_rdy_i,
    output logic [DMA_XFER_ID_W-1:0]  issue_id_o,
    output logic [SRC_ADDR_W-1:0]     issue_src_addr_o,
    output logic [DST_ADDR_W-1:0]     issue_dst_addr_o,
    output logic [DMA_LENGTH_W-1:0]   issue_xlen_o,
    output logic [DMA_LENGTH_W-1:0]   issue_ylen_o,
    output logic [DMA_LENGTH_W-1:0]   issue_src_strd_o,
    output logic [DMA_LENGTH_W-1:0]   issue_dst_strd_o,
    input  logic                      xfer_cmpl_i,
    output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
    output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
    output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
    output logic [DMA_LENGTH_W-1:0]   active_xfer_len_o,
    output logic                      irq_com_o,
    output logic                      irq_qed_o
);

    localparam int CNT_W = DMA_XFER_ID_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DMA_DESC_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic [SRC_ADDR_W-1:0]   src_mem  [DMA_DESC_DEPTH];
    logic [DST_ADDR_W-1:0]   dst_mem  [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] xlen_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] ylen_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] sstr_mem [DMA_DESC_DEPTH];
    logic [DMA_LENGTH_W-1:0] dstr_mem [DMA_DESC_DEPTH];

    logic [DMA_XFER_ID_W-1:0]  wr_ptr, rd_ptr, active_id;
    logic [CNT_W-1:0]          count;
    logic [DMA_DESC_DEPTH-1:0] done, done_nxt;
    logic [DMA_LENGTH_W-1:0]   active_len;
    logic                      cyc_hold, issued, offer;
    logic                      push, pop, issue_fire, cmpl_fire;

    assign desc_wr_rdy_o = (count != DEPTH_C);
    assign push          = desc_wr_vld_i & desc_wr_rdy_o;
    assign issue_fire    = offer & issue_rdy_i;
    assign cmpl_fire     = (state == BUSY) & xfer_cmpl_i;
    // A cyclic issue keeps its slot; it is released at completion once cyclic drops
    assign pop = (issue_fire & ~chn_cyclic_i)
               | (cmpl_fire & cyc_hold & ~chn_cyclic_i);

    always_comb begin
        state_nxt = state;
        offer     = 1'b0;
        unique case (state)
            IDLE: begin
                offer = dma_en_i & chn_en_i & (count != '0);
                if (offer && issue_rdy_i) state_nxt = BUSY;
            end
            BUSY: if (xfer_cmpl_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Push to a slot overrides a same-cycle completion of that slot
    always_comb begin
        done_nxt = done;
        if (cmpl_fire) done_nxt[active_id] = 1'b1;
        if (push) done_nxt[wr_ptr] = 1'b0;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done       <= '0;
            active_id  <= '0;
            active_len <= '0;
            cyc_hold   <= 1'b0;
            issued     <= 1'b0;
            for (int i = 0; i < DMA_DESC_DEPTH; i++) begin
                src_mem[i]  <= '0;
                dst_mem[i]  <= '0;
                xlen_mem[i] <= '0;
                ylen_mem[i] <= '0;
                sstr_mem[i] <= '0;
                dstr_mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (push) begin
                src_mem[wr_ptr]  <= desc_src_addr_i;
                dst_mem[wr_ptr]  <= desc_dst_addr_i;
                xlen_mem[wr_ptr] <= desc_xlen_i;
                ylen_mem[wr_ptr] <= desc_ylen_i;
                sstr_mem[wr_ptr] <= desc_src_strd_i;
                dstr_mem[wr_ptr] <= desc_dst_strd_i;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (issue_fire) begin
                active_id  <= rd_ptr;
                active_len <= xlen_mem[rd_ptr];
                cyc_hold   <= chn_cyclic_i;
                issued     <= 1'b1;
            end else if (cmpl_fire) begin
                cyc_hold <= 1'b0;
            end
        end
    end

    assign issue_vld_o       = offer;
    assign issue_id_o        = rd_ptr;
    assign issue_src_addr_o  = src_mem[rd_ptr];
    assign issue_dst_addr_o  = dst_mem[rd_ptr];
    assign issue_xlen_o      = xlen_mem[rd_ptr];
    assign issue_ylen_o      = ylen_mem[rd_ptr];
    assign issue_src_strd_o  = sstr_mem[rd_ptr];
    assign issue_dst_strd_o  = dstr_mem[rd_ptr];
    assign xfer_id_o         = wr_ptr;
    assign xfer_done_o       = done;
    assign active_xfer_id_o  = active_id;
    assign active_xfer_len_o = active_len;
    assign irq_com_o = irq_msk_com_i & (|done);
    assign irq_qed_o = irq_msk_qed_i & (count == '0) & (state == IDLE) & issued;

endmodule

// File: tb/tb_adma_desc_queue.sv
// Directed self-checking bench for adma_desc_queue.
`timescale 1ns/1ps
module tb_adma_desc_queue;

    logic        aclk = 1'b0;
    logic        areset;
    logic        dma_en, chn_en, chn_cyclic, msk_com, msk_qed;
    logic        wr_vld, wr_rdy;
    logic [31:0] src, dst;
    logic [15:0] xlen, ylen, sstr, dstr;
    logic        i_vld, i_rdy;
    logic [1:0]  i_id;
    logic [31:0] i_src, i_dst;
    logic [15:0] i_xlen, i_ylen, i_sstr, i_dstr;
    logic        cmpl;
    logic [1:0]  xfer_id, act_id;
    logic [3:0]  done;
    logic [15:0] act_len;
    logic        irq_com, irq_qed;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    adma_desc_queue dut (
        .aclk(aclk), .areset(areset),
        .dma_en_i(dma_en), .chn_en_i(chn_en), .chn_cyclic_i(chn_cyclic),
        .irq_msk_com_i(msk_com), .irq_msk_qed_i(msk_qed),
        .desc_wr_vld_i(wr_vld), .desc_wr_rdy_o(wr_rdy),
        .desc_src_addr_i(src), .desc_dst_addr_i(dst),
        .desc_xlen_i(xlen), .desc_ylen_i(ylen),
        .desc_src_strd_i(sstr), .desc_dst_strd_i(dstr),
        .issue_vld_o(i_vld), .issue_rdy_i(i_rdy), .issue_id_o(i_id),
        .issue_src_addr_o(i_src), .issue_dst_addr_o(i_dst),
        .issue_xlen_o(i_xlen), .issue_ylen_o(i_ylen),
        .issue_src_strd_o(i_sstr), .issue_dst_strd_o(i_dstr),
        .xfer_cmpl_i(cmpl), .xfer_id_o(xfer_id), .xfer_done_o(done),
        .active_xfer_id_o(act_id), .active_xfer_len_o(act_len),
        .irq_com_o(irq_com), .irq_qed_o(irq_qed)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        wr_vld = 0; i_rdy = 0; cmpl = 0; chn_cyclic = 0;
        dma_en = 1; chn_en = 1; msk_com = 1; msk_qed = 1;
        areset = 1;
        step();
        areset = 0;
        #1;
    endtask

    task automatic set_desc(input logic [31:0] s, input logic [15:0] xl);
        src = s; dst = s + 32'h8000_0000; xlen = xl;
        ylen = xl + 16'd1; sstr = xl + 16'd2; dstr = xl + 16'd3;
    endtask

    task automatic test_reset();
        areset = 1;
        wr_vld = 0; i_rdy = 0; cmpl = 0; chn_cyclic = 0;
        dma_en = 1; chn_en = 1; msk_com = 1; msk_qed = 1;
        set_desc(32'h0, 16'h0);
        step();
        checks++;
        if ({wr_rdy, i_vld, xfer_id, done, irq_com, irq_qed} !== 10'b1_0_00_0000_0_0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1000000000",
                     {wr_rdy, i_vld, xfer_id, done, irq_com, irq_qed});
        end
        checks++;
        if ({act_id, act_len, i_src, i_xlen} !== 66'd0) begin
            errors++;
            $display("FAIL reset_fields got %h exp 0", {act_id, act_len, i_src, i_xlen});
        end
        areset = 0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        set_desc(32'h1000, 16'd8);
        wr_vld = 1;
        step();
        wr_vld = 0;
        #1;
        checks++;
        if ({i_vld, i_id, i_src, i_xlen} !== {1'b1, 2'd0, 32'h1000, 16'd8}) begin
            errors++;
            $display("FAIL single_offer got %h exp %h", {i_vld, i_id, i_src, i_xlen},
                     {1'b1, 2'd0, 32'h1000, 16'd8});
        end
        checks++;
        if ({i_dst, i_ylen, i_sstr, i_dstr} !== {32'h8000_1000, 16'd9, 16'd10, 16'd11}) begin
            errors++;
            $display("FAIL single_fields got %h", {i_dst, i_ylen, i_sstr, i_dstr});
        end
        i_rdy = 1;
        step();
        i_rdy = 0;
        #1;
        checks++;
        if ({i_vld, act_id, act_len, irq_qed} !== {1'b0, 2'd0, 16'd8, 1'b0}) begin
            errors++;
            $display("FAIL single_busy got %h exp %h", {i_vld, act_id, act_len, irq_qed},
                     {1'b0, 2'd0, 16'd8, 1'b0});
        end
        cmpl = 1;
        step();
        cmpl = 0;
        #1;
        checks++;
        if ({done, irq_com, irq_qed, act_len} !== {4'b0001, 1'b1, 1'b1, 16'd8}) begin
            errors++;
            $display("FAIL single_cmpl got %h exp %h", {done, irq_com, irq_qed, act_len},
                     {4'b0001, 1'b1, 1'b1, 16'd8});
        end
        msk_com = 0; msk_qed = 0;
        #1;
        checks++;
        if ({irq_com, irq_qed} !== 2'b00) begin
            errors++;
            $display("FAIL irq_mask got %b exp 00", {irq_com, irq_qed});
        end
        msk_com = 1; msk_qed = 1;
    endtask

    task automatic test_full();
        do_reset();
        wr_vld = 1;
        for (int k = 0; k < 4; k++) begin
            set_desc(32'h100 * (k + 1), 16'(k + 1));
            step();
        end
        set_desc(32'h5000, 16'd5);
        #1;
        checks++;
        if ({wr_rdy, xfer_id, i_vld, i_id, i_src} !== {1'b0, 2'd0, 1'b1, 2'd0, 32'h100}) begin
            errors++;
            $display("FAIL full_state got %h exp %h", {wr_rdy, xfer_id, i_vld, i_id, i_src},
                     {1'b0, 2'd0, 1'b1, 2'd0, 32'h100});
        end
        step();
        checks++;
        if ({wr_rdy, xfer_id} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL full_hold got %b exp 000", {wr_rdy, xfer_id});
        end
        i_rdy = 1;
        step();
        i_rdy = 0;
        #1;
        checks++;
        if ({wr_rdy, i_vld, act_len} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL full_pop got %h exp %h", {wr_rdy, i_vld, act_len},
                     {1'b1, 1'b0, 16'd1});
        end
        step();
        wr_vld = 0;
        #1;
        checks++;
        if ({xfer_id, wr_rdy} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL full_wrap got %b exp 010", {xfer_id, wr_rdy});
        end
    endtask

    task automatic test_cyclic();
        do_reset();
        chn_cyclic = 1;
        set_desc(32'h2000, 16'd3);
        wr_vld = 1;
        step();
        wr_vld = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({i_vld, i_id, i_xlen} !== {1'b1, 2'd0, 16'd3}) begin
                errors++;
                $display("FAIL cyclic_offer%0d got %h exp %h", k, {i_vld, i_id, i_xlen},
                         {1'b1, 2'd0, 16'd3});
            end
            i_rdy = 1;
            step();
            i_rdy = 0;
            cmpl = 1;
            step();
            cmpl = 0;
        end
        #1;
        checks++;
        if ({i_vld, i_id, irq_qed, done} !== {1'b1, 2'd0, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL cyclic_after3 got %h exp %h", {i_vld, i_id, irq_qed, done},
                     {1'b1, 2'd0, 1'b0, 4'b0001});
        end
        i_rdy = 1;
        step();
        i_rdy = 0;
        chn_cyclic = 0;
        cmpl = 1;
        step();
        cmpl = 0;
        #1;
        checks++;
        if ({irq_qed, i_vld, wr_rdy} !== 3'b101) begin
            errors++;
            $display("FAIL cyclic_drain got %b exp 101", {irq_qed, i_vld, wr_rdy});
        end
    endtask

    task automatic test_enable();
        do_reset();
        chn_en = 0;
        wr_vld = 1;
        set_desc(32'h3000, 16'd10);
        step();
        set_desc(32'h3100, 16'd11);
        step();
        wr_vld = 0;
        #1;
        checks++;
        if ({i_vld, irq_qed} !== 2'b00) begin
            errors++;
            $display("FAIL en_off got %b exp 00", {i_vld, irq_qed});
        end
        chn_en = 1;
        #1;
        checks++;
        if ({i_vld, i_id, i_xlen} !== {1'b1, 2'd0, 16'd10}) begin
            errors++;
            $display("FAIL en_first got %h exp %h", {i_vld, i_id, i_xlen},
                     {1'b1, 2'd0, 16'd10});
        end
        i_rdy = 1;
        step();
        i_rdy = 0;
        cmpl = 1;
        step();
        cmpl = 0;
        #1;
        checks++;
        if ({i_vld, i_id, i_xlen} !== {1'b1, 2'd1, 16'd11}) begin
            errors++;
            $display("FAIL en_second got %h exp %h", {i_vld, i_id, i_xlen},
                     {1'b1, 2'd1, 16'd11});
        end
        i_rdy = 1;
        step();
        i_rdy = 0;
        chn_en = 0;
        #1;
        checks++;
        if ({act_id, act_len} !== {2'd1, 16'd11}) begin
            errors++;
            $display("FAIL en_active got %h exp %h", {act_id, act_len}, {2'd1, 16'd11});
        end
        cmpl = 1;
        step();
        cmpl = 0;
        #1;
        checks++;
        if ({i_vld, done, irq_qed} !== {1'b0, 4'b0011, 1'b1}) begin
            errors++;
            $display("FAIL en_drop_busy got %b exp 000111", {i_vld, done, irq_qed});
        end
        chn_en = 1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_vld = 1;
        for (int k = 0; k < 4; k++) begin
            set_desc(32'h400 * (k + 1), 16'(20 + k));
            step();
        end
        wr_vld = 0;
        i_rdy = 1;
        step();
        i_rdy = 0;
        set_desc(32'h9000, 16'd99);
        wr_vld = 1;
        cmpl = 1;
        step();
        wr_vld = 0;
        cmpl = 0;
        #1;
        checks++;
        if ({done, irq_com, xfer_id, wr_rdy} !== {4'b0000, 1'b0, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL push_wins got %b exp 00000010", {done, irq_com, xfer_id, wr_rdy});
        end
        checks++;
        if ({i_vld, i_id, i_xlen} !== {1'b1, 2'd1, 16'd21}) begin
            errors++;
            $display("FAIL b2b_next got %h exp %h", {i_vld, i_id, i_xlen},
                     {1'b1, 2'd1, 16'd21});
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        wr_vld = 1;
        for (int k = 0; k < 4; k++) begin
            set_desc(32'h600 * (k + 1), 16'(30 + k));
            step();
        end
        wr_vld = 0;
        i_rdy = 1;
        step();
        i_rdy = 0;
        areset = 1;
        #1;
        checks++;
        if ({wr_rdy, i_vld, xfer_id, act_id, act_len, done, i_src} !==
            {1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_busy got %h", {wr_rdy, i_vld, xfer_id, act_id, act_len, done, i_src});
        end
        #2;
        areset = 0;
        #1;
        cmpl = 1;
        step();
        cmpl = 0;
        #1;
        checks++;
        if ({done, irq_com, irq_qed, i_vld, wr_rdy} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL rst_cmpl_ignored got %b exp 00000001",
                     {done, irq_com, irq_qed, i_vld, wr_rdy});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_cyclic();
        test_enable();
        test_back_to_back();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
